// File: rtl/mxu_in_skew.sv
// Diagonal input skew between the RAM buffer and the MXU systolic array.
// Lane i is delayed i+1 cycles; it also counts rows and drains the pipe on a flush request.
module mxu_in_skew #(
    parameter int LANE_NUM   = 16,
    parameter int LANE_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [LANE_NUM-1:0]            ram_buff_mxu_vld,
    input  logic [LANE_NUM*LANE_WIDTH-1:0] ram_buff_mxu_data,
    input  logic                           skew_flush_req,
    output logic [LANE_NUM-1:0]            skew_mxu_vld,
    output logic [LANE_NUM*LANE_WIDTH-1:0] skew_mxu_data,
    output logic                           skew_busy,
    output logic                           skew_flush_done,
    output logic [CNT_WIDTH-1:0]           skew_row_cnt,
    output logic                           skew_drop_err
);

    localparam int               DRAIN_W    = 5;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(LANE_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               capture;
    logic               any_vld;
    logic               row_beat;
    logic [LANE_NUM-1:0] cap_vld;

    assign capture  = (state != FLUSH);
    assign any_vld  = |ram_buff_mxu_vld;
    assign row_beat = any_vld & capture;
    // While draining, inputs are replaced by zeros so the chains empty out.
    assign cap_vld  = ram_buff_mxu_vld & {LANE_NUM{capture}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            drain_cnt       <= '0;
            skew_busy       <= 1'b0;
            skew_flush_done <= 1'b0;
            skew_row_cnt    <= '0;
            skew_drop_err   <= 1'b0;
        end else begin
            skew_flush_done <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (row_beat) begin
                        skew_row_cnt <= skew_row_cnt + CNT_WIDTH'(1);
                        state        <= RUN;
                        skew_busy    <= 1'b1;
                    end
                    if (skew_flush_req) begin
                        state           <= FLUSH;
                        skew_busy       <= 1'b1;
                        drain_cnt       <= DRAIN_INIT;
                        skew_flush_done <= (DRAIN_INIT == '0);
                    end
                end
                FLUSH: begin
                    if (any_vld) begin
                        skew_drop_err <= 1'b1;
                    end
                    // done is registered, so it is raised one count early to land on the last drain cycle
                    if (drain_cnt == '0) begin
                        state        <= IDLE;
                        skew_busy    <= 1'b0;
                        skew_row_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                        if (drain_cnt == DRAIN_W'(1)) begin
                            skew_flush_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    skew_busy <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        logic [i:0]            vld_p;
        logic [LANE_WIDTH-1:0] data_p [0:i];
        logic [LANE_WIDTH-1:0] cap_data;

        assign cap_data = ram_buff_mxu_data[i*LANE_WIDTH +: LANE_WIDTH] & {LANE_WIDTH{cap_vld[i]}};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= '0;
                for (int k = 0; k <= i; k++) begin
                    data_p[k] <= '0;
                end
            end else begin
                vld_p[0]  <= cap_vld[i];
                data_p[0] <= cap_data;
                for (int k = 1; k <= i; k++) begin
                    vld_p[k]  <= vld_p[k-1];
                    data_p[k] <= data_p[k-1];
                end
            end
        end

        assign skew_mxu_vld[i]                               = vld_p[i];
        assign skew_mxu_data[i*LANE_WIDTH +: LANE_WIDTH] = data_p[i];
    end

endmodule
